// File: rtl/data_mem_mp.sv
// rtl/data_mem_mp.sv - 2**AW x DW memory, one write port, two read ports, built-in clear sequencer.
// Define DATA_MEM_MP_RD_REG_EN for registered read ports with write-first bypass.
module data_mem_mp #(
   parameter int            AW        = 8,
   parameter int            DW        = 8,
   parameter logic [DW-1:0] CLEAR_VAL = '0
) (
   input  logic          clk,
   input  logic          Reset_n,
   input  logic [AW-1:0] WriteAddr,
   input  logic          WriteMem,
   input  logic [DW-1:0] DataIn,
   input  logic [AW-1:0] ReadAddrA,
   output logic [DW-1:0] DataOutA,
   input  logic [AW-1:0] ReadAddrB,
   output logic [DW-1:0] DataOutB,
   input  logic          ClearReq,
   output logic          Ready
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t        r_state;
   logic [AW-1:0] r_clr_addr;
   logic          r_ready;
   logic [DW-1:0] r_mem [DEPTH];

   logic          w_clearing;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;

   // The sequencer owns the write port while clearing; user writes are dropped.
   assign w_clearing = (r_state == S_CLEAR);
   assign w_we       = Reset_n & (w_clearing | WriteMem);
   assign w_waddr    = w_clearing ? r_clr_addr : WriteAddr;
   assign w_wdata    = w_clearing ? CLEAR_VAL  : DataIn;
   assign Ready      = r_ready;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= S_CLEAR;
         r_clr_addr <= '0;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == {AW{1'b1}}) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (ClearReq) begin
                  r_state    <= S_CLEAR;
                  r_clr_addr <= '0;
                  r_ready    <= 1'b0;
               end
            end
            default: begin
               r_state <= S_CLEAR;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

`ifdef DATA_MEM_MP_RD_REG_EN
   // Write-first: a same-cycle write (user or clear) to the read address is captured directly.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         DataOutA <= '0;
         DataOutB <= '0;
      end else begin
         DataOutA <= (w_we && (w_waddr == ReadAddrA)) ? w_wdata : r_mem[ReadAddrA];
         DataOutB <= (w_we && (w_waddr == ReadAddrB)) ? w_wdata : r_mem[ReadAddrB];
      end
   end
`else
   assign DataOutA = r_mem[ReadAddrA];
   assign DataOutB = r_mem[ReadAddrB];
`endif

endmodule

// File: tb/tb_data_mem_mp.sv
// tb/tb_data_mem_mp.sv - randomized scoreboard bench for data_mem_mp (AW=4, CLEAR_VAL=8'hA5).
module tb_data_mem_mp;

   localparam int           AW    = 4;
   localparam int           DW    = 8;
   localparam int           DEPTH = 16;
   localparam logic [7:0]   CV    = 8'hA5;

   logic          clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [AW-1:0] WriteAddr = '0;
   logic          WriteMem = 1'b0;
   logic [DW-1:0] DataIn = '0;
   logic [AW-1:0] ReadAddrA = '0;
   logic [AW-1:0] ReadAddrB = '0;
   logic [DW-1:0] DataOutA;
   logic [DW-1:0] DataOutB;
   logic          ClearReq = 1'b0;
   logic          Ready;

   data_mem_mp #(.AW(AW), .DW(DW), .CLEAR_VAL(CV)) dut (
      .clk(clk), .Reset_n(Reset_n),
      .WriteAddr(WriteAddr), .WriteMem(WriteMem), .DataIn(DataIn),
      .ReadAddrA(ReadAddrA), .DataOutA(DataOutA),
      .ReadAddrB(ReadAddrB), .DataOutB(DataOutB),
      .ClearReq(ClearReq), .Ready(Ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rdy;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   drv_done = 1'b0;

   // Reference model: word contents plus the number of clear writes still owed.
   logic [7:0] mdl_mem [DEPTH];
   int         clr_left = DEPTH;
   logic [7:0] nxt_a = 8'h00;
   logic [7:0] nxt_b = 8'h00;

   task automatic step(input logic rst, input logic we, input logic [3:0] wa,
                       input logic [7:0] din, input logic [3:0] ra,
                       input logic [3:0] rb, input logic creq);
      exp_t       e;
      logic       wr;
      logic [3:0] waddr;
      logic [7:0] wdat;
      Reset_n   = rst;
      WriteMem  = we;
      WriteAddr = wa;
      DataIn    = din;
      ReadAddrA = ra;
      ReadAddrB = rb;
      ClearReq  = creq;
      if (!rst) begin
         clr_left = DEPTH;
         e.rdy = 1'b0;
`ifdef DATA_MEM_MP_RD_REG_EN
         e.a = 8'h00;
         e.b = 8'h00;
`else
         e.a = mdl_mem[ra];
         e.b = mdl_mem[rb];
`endif
         nxt_a = 8'h00;
         nxt_b = 8'h00;
         q.push_back(e);
      end else begin
         e.rdy = (clr_left == 0);
`ifdef DATA_MEM_MP_RD_REG_EN
         e.a = nxt_a;
         e.b = nxt_b;
`else
         e.a = mdl_mem[ra];
         e.b = mdl_mem[rb];
`endif
         q.push_back(e);
         if (clr_left > 0) begin
            wr = 1'b1;
            waddr = 4'(DEPTH - clr_left);
            wdat = CV;
         end else begin
            wr = we;
            waddr = wa;
            wdat = din;
         end
         nxt_a = (wr && waddr == ra) ? wdat : mdl_mem[ra];
         nxt_b = (wr && waddr == rb) ? wdat : mdl_mem[rb];
         if (wr) mdl_mem[waddr] = wdat;
         if (clr_left > 0) clr_left--;
         else if (creq) clr_left = DEPTH;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 4'h0, 8'h00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() == 0) begin
            if (!drv_done) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: no expectation queued at %0t", $time);
            end
         end else begin
            e = q.pop_front();
            n_checks++;
            if (Ready !== e.rdy) begin
               n_fail++;
               $display("FAIL ready at %0t: got %b want %b", $time, Ready, e.rdy);
            end
            if (!$isunknown(e.a)) begin
               n_checks++;
               if (DataOutA !== e.a) begin
                  n_fail++;
                  $display("FAIL dout_a at %0t addr %0d: got %h want %h", $time, ReadAddrA, DataOutA, e.a);
               end
            end
            if (!$isunknown(e.b)) begin
               n_checks++;
               if (DataOutB !== e.b) begin
                  n_fail++;
                  $display("FAIL dout_b at %0t addr %0d: got %h want %h", $time, ReadAddrB, DataOutB, e.b);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'hxx;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 8'h00, 4'(i), 4'(i), 1'b0);
      // Initial clear with a dropped write to addr 2 after it has been cleared.
      for (int i = 0; i < 16; i++)
         step(1'b1, (i == 5), 4'h2, 8'hFF, 4'(i), 4'h2, 1'b0);
      idle(4);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'h0, 8'h00, 4'(i), 4'(15 - i), 1'b0);
      // Write then read back, neighbour still cleared.
      step(1'b1, 1'b1, 4'h7, 8'h3C, 4'h0, 4'h1, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'h7, 4'h6, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'h7, 4'h6, 1'b0);
      // ClearReq restarts the sequence; a second pulse mid-clear is ignored.
      step(1'b1, 1'b1, 4'hF, 8'h11, 4'hF, 4'h7, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'hF, 4'h7, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'hF, 4'h7, 1'b1);
      idle(8);
      step(1'b1, 1'b1, 4'hE, 8'h77, 4'hF, 4'h7, 1'b1);
      idle(10);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'hF, 4'h2, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'hF, 4'hE, 1'b0);
      // Reset asserted at clear cycle 5.
      step(1'b1, 1'b1, 4'h9, 8'h42, 4'h9, 4'h9, 1'b1);
      idle(5);
      step(1'b0, 1'b0, 4'h0, 8'h00, 4'h9, 4'h0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 8'h00, 4'h9, 4'h0, 1'b0);
      idle(18);
      // Same-cycle write and read of addr 3.
      step(1'b1, 1'b1, 4'h3, 8'h5A, 4'h3, 4'h3, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'h3, 4'h3, 1'b0);
      step(1'b1, 1'b0, 4'h0, 8'h00, 4'h3, 4'h4, 1'b0);
      for (int i = 0; i < 400; i++) begin
         logic [3:0] ra;
         ra = 4'($urandom_range(0, 15));
         step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), ra,
              ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15)),
              ($urandom_range(0, 39) == 0));
      end
      drv_done = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_mp.md
Name: data_mem_mp

Overview:
- Parametrised multi-port data memory for the next-generation core. Generalises the current single-port 8-bit memory.
- One clocked write port, two independent read ports (A: load unit, B: debug/testbench peek). Width and depth are set by parameters.
- Built-in clear sequencer fills every word with a constant after reset or on request. A Ready flag gates software use.

Parameters:
- AW, 8, address width; depth = 2**AW words.
- DW, 8, data word width in bits.
- CLEAR_VAL, 0, DW-bit value written to every word by the clear sequencer.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- WriteAddr  input  AW  write address.
- WriteMem  input  1  write enable.
- DataIn  input  DW  write data.
- ReadAddrA  input  AW  read port A address.
- DataOutA  output  DW  read port A data.
- ReadAddrB  input  AW  read port B address.
- DataOutB  output  DW  read port B data.
- ClearReq  input  1  one-cycle pulse: restart clear sequence.
- Ready  output  1  high when clear sequence done and user writes are accepted.

Behaviour:
- Storage: 2**AW x DW array. The array itself is not reset; only the sequencer state is reset.
- Reset (Reset_n low, async):
  - state=CLEAR, ClrAddr=0, Ready=0.
  - Read outputs follow the array (combinational build), or 0 (registered build).
- FSM states:
  - CLEAR: every cycle writes CLEAR_VAL to mem[ClrAddr], then ClrAddr increments (AW bits).
    - When the write of ClrAddr == 2**AW-1 occurs, next state is IDLE and Ready=1 from the following cycle.
    - Total 2**AW cycles from reset release to Ready=1.
  - IDLE: Ready=1. WriteMem=1 writes DataIn to mem[WriteAddr] on the rising edge.
    - ClearReq=1 -> next state CLEAR, ClrAddr=0, Ready=0 next cycle. Any write in that same cycle is still performed, then overwritten by the clear when reached.
- Writes during CLEAR: WriteMem is ignored and the data is dropped, with no error flag. Software must poll Ready.
- ClearReq during CLEAR: ignored; the sequence is not restarted.
- Reset asserted mid-clear: the sequence restarts from address 0 after release.
- Reads:
  - Both ports are usable in any state. During CLEAR they return current contents, which may be partially cleared.
  - Default build: DataOutX = mem[ReadAddrX] combinationally, zero latency.
  - Same-cycle read and write to the same address returns the old value; the new value is visible after the edge.
- ClrAddr wraps naturally at 2**AW; the wrap coincides with the exit to IDLE, so no extra cycle.
- Read ports A and B may use the same address simultaneously; both return identical data.

Optional Feature:
- Macro: DATA_MEM_MP_RD_REG_EN.
- Defined:
  - DataOutA and DataOutB are registered, giving one-cycle read latency: address presented in cycle N, data valid in N+1.
  - Registers reset asynchronously to 0.
  - Write-first bypass: if WriteMem is accepted (IDLE) to the same address as ReadAddrX in the same cycle, DataOutX captures DataIn.
  - During CLEAR, a read of the address being cleared that cycle captures CLEAR_VAL.
- Undefined: combinational reads as described above, with no bypass logic.

Test Plan:
- Reset release, AW=4, CLEAR_VAL=8'hA5:
  - Ready=0 for cycles 0-15 and Ready=1 at cycle 16.
  - Reading all 16 addresses on both ports returns 8'hA5.
- IDLE, write 8'h3C to addr 7:
  - Next cycle ReadAddrA=7 -> DataOutA=8'h3C, while ReadAddrB=6 -> 8'hA5.
  - Registered build: values appear one cycle later.
- During CLEAR, WriteMem=1 addr 2 data 8'hFF:
  - After Ready=1, addr 2 reads CLEAR_VAL; the write is dropped.
- IDLE, ClearReq pulse after writing 8'h11 to addr 15:
  - Ready drops next cycle and returns after 16 cycles.
  - Addr 15 then reads CLEAR_VAL. A ClearReq pulse mid-clear does not extend the duration.
- Reset_n asserted at clear cycle 5:
  - Ready stays 0, the sequence restarts, and Ready rises 16 cycles after release.
  - Registered build: outputs read 0 while in reset.
- Registered build, same-cycle write 8'h5A and read on port A at addr 3:
  - DataOutA=8'h5A next cycle (bypass).
  - Combinational build: old value in the same cycle, 8'h5A after the edge.
